smu_seq_matcher: RTL and testbench
==================================

# smu_seq_matcher

Next-generation signal monitor unit: M independent sequence-match channels, each walking up to N programmable compare states over a K-bit observable bus. Adds per-state inter-stage timeouts, per-channel depth, pulse or sticky trigger modes, and a double-buffered configuration file with atomic commit. Sits beside the host logic it observes, after the bitstream loader/decrypt path, which drives its configuration write port.

## Interface
- N, 4: max states per channel (≥2); SW = $clog2(N)
- K, 8: observable bus width
- M, 4: channel count; CW = max(1,$clog2(M))
- CNT_W, 8: timeout counter width; entry width E = 2K+1+CNT_W (must satisfy E ≥ 2+SW)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- p  in  K  observable signals, sampled each clk
- SmuEn  in  1  global enable
- CfgWrEn  in  1  write strobe into shadow config
- CfgWrSel  in  1  0 = state entry, 1 = channel control
- CfgChan  in  CW  target channel
- CfgState  in  SW  target state (ignored when CfgWrSel=1)
- CfgWrData  in  E  entry: {Cmp[K], Mask[K], Sel, Timeout[CNT_W]} MSB→LSB; control: bit0 Enable, bit1 Sticky, bits[2+:SW] LastState
- CfgCommit  in  1  copy whole shadow to active in one cycle
- TrigClr  in  M  clear sticky trigger per channel
- trigger  out  M  registered trigger
- TimeoutEvt  out  M  one-cycle pulse when a channel times out
- SmuState  out  M*SW  current state per channel, channel c at [c*SW+:SW]

## Operation
- Match(s) = Sel ? ((p&Mask)==(Cmp&Mask)) : ((p&Mask)!=(Cmp&Mask)); Mask=0,Sel=1 always matches.
- Channel active iff SmuEn & Enable. Inactive: state 0, counter 0, non-sticky trigger 0; sticky trigger retained.
- Active, state s: Match → s+1 (counter 0); Match with s==LastState → state 0 and fire.
- No match, s>0: counter++; if Timeout≠0 and counter==Timeout-1 → state 0, TimeoutEvt pulse. State 0 never times out. Timeout=0 disables.
- Match beats timeout in the same cycle.
- Fire: pulse mode → trigger high exactly one cycle; sticky → trigger holds until TrigClr. Fire and TrigClr same cycle → stays 1.
- LastState > N-1 is impossible by width; LastState=0 gives single-state depth.
- Writes go only to shadow; active config unchanged until CfgCommit.
- CfgCommit: shadow→active; all channels to state 0, counters 0, trigger 0 (incl. sticky), TimeoutEvt 0. Commit beats any same-cycle match/fire/timeout. CfgWrEn with CfgCommit same cycle: write lands in shadow and is included in that commit.
- CfgChan ≥ M: write ignored.

## Timing
- Reset (async assert, sync deassert by upstream): shadow and active all zero (all channels disabled), SmuState 0, trigger 0, TimeoutEvt 0.
- p sampled at edge t; state/trigger/TimeoutEvt update at edge t → visible cycle t+1. Trigger latency: one cycle after last matching sample.
- Timeout T: after entering s>0, T consecutive non-matching samples return to 0; the first sample in state s counts.
- New config effective for samples from the cycle after commit.
- Depth-1 pulse channel with persistent match: trigger high every cycle.

## Structure
- smu_pkg: CfgWrSel encodings (CFG_SEL_STATE, CFG_SEL_CTRL), control-field bit offsets, entry-field offset functions of K/CNT_W.
- Sub-module smu_seq_channel: one channel FSM, counter, trigger logic; top generates M instances and holds shadow/active files plus commit muxing.

## Test plan
K=4, N=4, M=2, CNT_W=4 throughout.
- Ch0 pulse, LastState=1, s0 {A,F,1,0}, s1 {5,F,1,0}: p=A,5 → SmuState 0→1→0, trigger[0] high one cycle after 5 sampled.
- Same, s1 Timeout=3: p=A,0,0,0,5 → back to 0 after third 0, TimeoutEvt[0] one pulse, no trigger; p=A,0,5 → trigger.
- Ch1 sticky, single state {C,F,1,0}: p=C → trigger[1] stays 1 across p=0; TrigClr[1] → 0; TrigClr[1] with p=C → remains 1.
- Ch0 s0 {0,3,0,0}: p=C → no match; p=1 → match. Shadow write changing Cmp without commit → behaviour unchanged.
- In state 1, pulse CfgCommit with p=5 → no trigger, state 0, new config effective next cycle; sticky trigger cleared by commit.
- SmuEn low mid-sequence → state 0; assert rst mid-sequence → all outputs 0 immediately, channels disabled after release.

Source files
------------

// File: rtl/smu_pkg.sv
// Shared encodings and field layout for the sequence-match monitor.
// Entry layout MSB->LSB is {Cmp[K], Mask[K], Sel, Timeout[CNT_W]}.
package smu_pkg;

  typedef enum logic {
    CFG_SEL_STATE = 1'b0,
    CFG_SEL_CTRL  = 1'b1
  } cfg_sel_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_STICKY_BIT = 1;
  localparam int CTRL_LAST_LSB   = 2;

  function automatic int entry_width(input int k, input int cnt_w);
    return 2 * k + 1 + cnt_w;
  endfunction

  function automatic int cmp_lsb(input int k, input int cnt_w);
    return k + 1 + cnt_w;
  endfunction

  function automatic int mask_lsb(input int cnt_w);
    return 1 + cnt_w;
  endfunction

  function automatic int sel_bit(input int cnt_w);
    return cnt_w;
  endfunction

endpackage

// File: rtl/smu_seq_channel.sv
// One match channel: state walker, inter-stage timeout counter and trigger.
// The entry for the current state is picked out of the flattened active file.
module smu_seq_channel
  import smu_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int K     = 8,
    parameter  int CNT_W = 8,
    localparam int SW    = $clog2(N),
    localparam int E     = 2 * K + 1 + CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [K-1:0]   p,
    input  logic           active,
    input  logic           sticky,
    input  logic [SW-1:0]  last_state,
    input  logic [N*E-1:0] entries,
    input  logic           commit,
    input  logic           trig_clr,
    output logic           trigger,
    output logic           timeout_evt,
    output logic [SW-1:0]  state
);

    localparam int CMP_LSB  = cmp_lsb(K, CNT_W);
    localparam int MASK_LSB = mask_lsb(CNT_W);
    localparam int SEL_BIT  = sel_bit(CNT_W);

    logic [E-1:0]     entry;
    logic [K-1:0]     cmp, mask;
    logic             sel, hit, fire, tmo_hit;
    logic [CNT_W-1:0] tmo, cnt, cnt_nxt;
    logic [SW-1:0]    state_nxt;
    logic             trig_nxt, tevt_nxt;

    assign entry = entries[state*E +: E];
    assign cmp   = entry[CMP_LSB +: K];
    assign mask  = entry[MASK_LSB +: K];
    assign sel   = entry[SEL_BIT];
    assign tmo   = entry[CNT_W-1:0];
    assign hit   = sel ? ((p & mask) == (cmp & mask)) : ((p & mask) != (cmp & mask));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= '0;
            cnt         <= '0;
            trigger     <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            trigger     <= trig_nxt;
            timeout_evt <= tevt_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fire      = 1'b0;
        tmo_hit   = 1'b0;
        if (commit || !active) begin
            state_nxt = '0;
            cnt_nxt   = '0;
        end else if (hit) begin
            cnt_nxt = '0;
            if (state == last_state) begin
                state_nxt = '0;
                fire      = 1'b1;
            end else begin
                state_nxt = state + SW'(1);
            end
        end else if (state != '0) begin
            // Compare against the pre-increment count: the first miss in a state counts.
            if (tmo != '0 && cnt == tmo - CNT_W'(1)) begin
                state_nxt = '0;
                cnt_nxt   = '0;
                tmo_hit   = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        trig_nxt = 1'b0;
        tevt_nxt = tmo_hit;
        if (commit) begin
            trig_nxt = 1'b0;
            tevt_nxt = 1'b0;
        end else if (sticky) begin
            trig_nxt = fire | (trigger & ~trig_clr);
        end else begin
            trig_nxt = fire;
        end
    end

endmodule

// File: rtl/smu_seq_matcher.sv
// Signal monitor top: double-buffered configuration (shadow/active) with
// atomic commit, feeding M independent sequence-match channels.
module smu_seq_matcher
  import smu_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int K     = 8,
    parameter  int M     = 4,
    parameter  int CNT_W = 8,
    localparam int SW    = $clog2(N),
    localparam int CW    = (M > 1) ? $clog2(M) : 1,
    localparam int E     = entry_width(K, CNT_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [K-1:0]    p,
    input  logic            SmuEn,
    input  logic            CfgWrEn,
    input  logic            CfgWrSel,
    input  logic [CW-1:0]   CfgChan,
    input  logic [SW-1:0]   CfgState,
    input  logic [E-1:0]    CfgWrData,
    input  logic            CfgCommit,
    input  logic [M-1:0]    TrigClr,
    output logic [M-1:0]    trigger,
    output logic [M-1:0]    TimeoutEvt,
    output logic [M*SW-1:0] SmuState
);

    localparam int CTRL_W = CTRL_LAST_LSB + SW;

    logic [E-1:0]      shadow_entry     [M][N];
    logic [E-1:0]      shadow_entry_nxt [M][N];
    logic [E-1:0]      active_entry     [M][N];
    logic [CTRL_W-1:0] shadow_ctrl      [M];
    logic [CTRL_W-1:0] shadow_ctrl_nxt  [M];
    logic [CTRL_W-1:0] active_ctrl      [M];

    // The next-shadow view includes a same-cycle write, so a commit captures it.
    always_comb begin
        shadow_entry_nxt = shadow_entry;
        shadow_ctrl_nxt  = shadow_ctrl;
        if (CfgWrEn && (32'(CfgChan) < M)) begin
            if (CfgWrSel == CFG_SEL_CTRL)
                shadow_ctrl_nxt[CfgChan] = CfgWrData[CTRL_W-1:0];
            else
                shadow_entry_nxt[CfgChan][CfgState] = CfgWrData;
        end
    end

    // NOTE: both config files are reset explicitly; a zeroed file is what
    // guarantees every channel comes out of reset disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < M; c++) begin
                shadow_ctrl[c] <= '0;
                active_ctrl[c] <= '0;
                for (int s = 0; s < N; s++) begin
                    shadow_entry[c][s] <= '0;
                    active_entry[c][s] <= '0;
                end
            end
        end else begin
            shadow_entry <= shadow_entry_nxt;
            shadow_ctrl  <= shadow_ctrl_nxt;
            if (CfgCommit) begin
                active_entry <= shadow_entry_nxt;
                active_ctrl  <= shadow_ctrl_nxt;
            end
        end
    end

    for (genvar c = 0; c < M; c++) begin : g_chan
        logic [N*E-1:0] flat;
        for (genvar s = 0; s < N; s++) begin : g_ent
            assign flat[s*E +: E] = active_entry[c][s];
        end

        smu_seq_channel #(
            .N    (N),
            .K    (K),
            .CNT_W(CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .p          (p),
            .active     (SmuEn & active_ctrl[c][CTRL_EN_BIT]),
            .sticky     (active_ctrl[c][CTRL_STICKY_BIT]),
            .last_state (active_ctrl[c][CTRL_LAST_LSB +: SW]),
            .entries    (flat),
            .commit     (CfgCommit),
            .trig_clr   (TrigClr[c]),
            .trigger    (trigger[c]),
            .timeout_evt(TimeoutEvt[c]),
            .state      (SmuState[c*SW +: SW])
        );
    end

endmodule

// File: tb/tb_smu_seq_matcher.sv
// Directed bench for smu_seq_matcher with K=4, N=4, M=2, CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_smu_seq_matcher;

    localparam int N = 4, K = 4, M = 2, CNT_W = 4;
    localparam int SW = 2, CW = 1, E = 13;

    logic            clk = 1'b0;
    logic            rst;
    logic [K-1:0]    p;
    logic            SmuEn, CfgWrEn, CfgWrSel, CfgCommit;
    logic [CW-1:0]   CfgChan;
    logic [SW-1:0]   CfgState;
    logic [E-1:0]    CfgWrData;
    logic [M-1:0]    TrigClr, trigger, TimeoutEvt;
    logic [M*SW-1:0] SmuState;

    int checks   = 0;
    int failures = 0;

    smu_seq_matcher #(.N(N), .K(K), .M(M), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .p         (p),
        .SmuEn     (SmuEn),
        .CfgWrEn   (CfgWrEn),
        .CfgWrSel  (CfgWrSel),
        .CfgChan   (CfgChan),
        .CfgState  (CfgState),
        .CfgWrData (CfgWrData),
        .CfgCommit (CfgCommit),
        .TrigClr   (TrigClr),
        .trigger   (trigger),
        .TimeoutEvt(TimeoutEvt),
        .SmuState  (SmuState)
    );

    always #5 clk = ~clk;

    function automatic logic [E-1:0] ent(input logic [3:0] cmp, input logic [3:0] mask,
                                         input logic sel, input logic [3:0] tmo);
        return {cmp, mask, sel, tmo};
    endfunction

    function automatic logic [E-1:0] ctrl(input logic [1:0] last, input logic sticky,
                                          input logic en);
        return E'({last, sticky, en});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic ch, input logic [1:0] st,
                      input logic [E-1:0] data);
        CfgWrEn = 1'b1; CfgWrSel = sel; CfgChan = ch; CfgState = st; CfgWrData = data;
        cyc();
        CfgWrEn = 1'b0;
    endtask

    task automatic commit();
        CfgCommit = 1'b1;
        cyc();
        CfgCommit = 1'b0;
    endtask

    initial begin
        rst = 1'b0; p = '0; SmuEn = 1'b0; CfgWrEn = 1'b0; CfgWrSel = 1'b0;
        CfgCommit = 1'b0; CfgChan = '0; CfgState = '0; CfgWrData = '0; TrigClr = '0;
        cyc(); cyc();
        check("rst_state", 32'(SmuState), 32'h0);
        check("rst_trig", 32'(trigger), 32'h0);
        check("rst_tevt", 32'(TimeoutEvt), 32'h0);
        rst = 1'b1;
        SmuEn = 1'b1;

        // Two-state pulse sequence A then 5.
        wr(1'b0, 1'b0, 2'd0, ent(4'hA, 4'hF, 1'b1, 4'h0));
        wr(1'b0, 1'b0, 2'd1, ent(4'h5, 4'hF, 1'b1, 4'h0));
        wr(1'b1, 1'b0, 2'd0, ctrl(2'd1, 1'b0, 1'b1));
        commit();
        check("seq_idle", 32'(SmuState), 32'h0);
        p = 4'hA; cyc();
        check("seq_s1", 32'(SmuState), 32'h1);
        check("seq_s1_trig", 32'(trigger), 32'h0);
        p = 4'h5; cyc();
        check("seq_fire_state", 32'(SmuState), 32'h0);
        check("seq_fire_trig", 32'(trigger), 32'h1);
        p = 4'h0; cyc();
        check("seq_pulse_end", 32'(trigger), 32'h0);

        // Timeout of 3 on state 1.
        wr(1'b0, 1'b0, 2'd1, ent(4'h5, 4'hF, 1'b1, 4'h3));
        commit();
        p = 4'hA; cyc();
        check("to_s1", 32'(SmuState), 32'h1);
        p = 4'h0; cyc();
        check("to_miss1", 32'(SmuState), 32'h1);
        check("to_miss1_evt", 32'(TimeoutEvt), 32'h0);
        cyc();
        check("to_miss2", 32'(SmuState), 32'h1);
        cyc();
        check("to_expire_state", 32'(SmuState), 32'h0);
        check("to_expire_evt", 32'(TimeoutEvt), 32'h1);
        check("to_expire_trig", 32'(trigger), 32'h0);
        cyc();
        check("to_evt_pulse", 32'(TimeoutEvt), 32'h0);
        p = 4'hA; cyc();
        p = 4'h0; cyc();
        check("to_partial", 32'(SmuState), 32'h1);
        p = 4'h5; cyc();
        check("to_partial_fire", 32'(trigger), 32'h1);
        p = 4'h0; cyc();

        // Channel 1: sticky, single state C.
        wr(1'b0, 1'b1, 2'd0, ent(4'hC, 4'hF, 1'b1, 4'h0));
        wr(1'b1, 1'b1, 2'd0, ctrl(2'd0, 1'b1, 1'b1));
        commit();
        p = 4'hC; cyc();
        check("sticky_set", 32'(trigger), 32'h2);
        p = 4'h0; cyc();
        check("sticky_hold", 32'(trigger), 32'h2);
        TrigClr = 2'b10; cyc();
        check("sticky_clr", 32'(trigger), 32'h0);
        p = 4'hC; cyc();
        check("sticky_fire_beats_clr", 32'(trigger), 32'h2);
        p = 4'h0; cyc();
        check("sticky_clr2", 32'(trigger), 32'h0);
        TrigClr = 2'b00;

        // Not-equal compare on masked bits; shadow write must not take effect.
        wr(1'b0, 1'b0, 2'd0, ent(4'h0, 4'h3, 1'b0, 4'h0));
        wr(1'b1, 1'b0, 2'd0, ctrl(2'd0, 1'b0, 1'b1));
        commit();
        p = 4'hC; cyc();
        check("ne_nomatch", 32'(trigger[0]), 32'h0);
        p = 4'h1; cyc();
        check("ne_match", 32'(trigger[0]), 32'h1);
        p = 4'h0;
        wr(1'b0, 1'b0, 2'd0, ent(4'h1, 4'h3, 1'b0, 4'h0));
        check("shadow_idle", 32'(trigger[0]), 32'h0);
        p = 4'h1; cyc();
        check("shadow_isolated", 32'(trigger[0]), 32'h1);
        p = 4'h0;

        // Commit in state 1 with a matching sample, plus same-cycle control write.
        wr(1'b0, 1'b0, 2'd0, ent(4'hA, 4'hF, 1'b1, 4'h0));
        wr(1'b0, 1'b0, 2'd1, ent(4'h5, 4'hF, 1'b1, 4'h0));
        wr(1'b1, 1'b0, 2'd0, ctrl(2'd1, 1'b0, 1'b1));
        commit();
        p = 4'hC; cyc();
        check("cm_sticky_set", 32'(trigger), 32'h2);
        p = 4'hA; cyc();
        check("cm_s1", 32'(SmuState), 32'h1);
        p = 4'h0;
        wr(1'b0, 1'b0, 2'd0, ent(4'h5, 4'hF, 1'b1, 4'h0));
        p = 4'h5; CfgCommit = 1'b1;
        wr(1'b1, 1'b0, 2'd0, ctrl(2'd0, 1'b0, 1'b1));
        CfgCommit = 1'b0;
        check("cm_no_fire", 32'(trigger), 32'h0);
        check("cm_state0", 32'(SmuState), 32'h0);
        cyc();
        check("cm_new_cfg", 32'(trigger), 32'h1);
        check("cm_new_state", 32'(SmuState), 32'h0);
        cyc();
        check("depth1_persist", 32'(trigger), 32'h1);
        p = 4'h0; cyc();
        check("depth1_stop", 32'(trigger), 32'h0);

        // Global enable drop mid-sequence.
        wr(1'b0, 1'b0, 2'd0, ent(4'hA, 4'hF, 1'b1, 4'h0));
        wr(1'b1, 1'b0, 2'd0, ctrl(2'd1, 1'b0, 1'b1));
        commit();
        p = 4'hA; cyc();
        check("en_s1", 32'(SmuState), 32'h1);
        SmuEn = 1'b0; p = 4'h0; cyc();
        check("en_off_state", 32'(SmuState), 32'h0);
        SmuEn = 1'b1; p = 4'h5; cyc();
        check("en_restart", 32'(trigger), 32'h0);

        // Reset mid-sequence.
        p = 4'hC; cyc();
        p = 4'hA; cyc();
        check("pre_rst_state", 32'(SmuState), 32'h1);
        check("pre_rst_trig", 32'(trigger), 32'h2);
        rst = 1'b0; #1;
        check("rst_async_state", 32'(SmuState), 32'h0);
        check("rst_async_trig", 32'(trigger), 32'h0);
        check("rst_async_tevt", 32'(TimeoutEvt), 32'h0);
        cyc();
        rst = 1'b1;
        p = 4'hC; cyc();
        check("post_rst_disabled", 32'(trigger), 32'h0);
        p = 4'hA; cyc();
        check("post_rst_state", 32'(SmuState), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
